// File: rtl/serial_deser_pkg.sv
// rtl/serial_deser_pkg.sv - shared types and constants for the serial deserializer
package serial_deser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } deser_state_t;

  // Word length shared with the 4-bit parallel-load serializer on the other end of the link
  localparam int DEFAULT_WIDTH = 4;

  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/deser_shift_reg.sv
// rtl/deser_shift_reg.sv - assembly shift register with first-bit load and look-ahead word
module deser_shift_reg #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             load_first,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word_next
);

  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] first_word;

  // word_next includes the bit being sampled now, so the top can latch a
  // completed word on the same edge that samples its last bit.
  generate
    if (MSB_FIRST) begin : g_msb
      assign word_next  = {word[WIDTH-2:0], bit_in};
      assign first_word = {{(WIDTH-1){1'b0}}, bit_in};
    end else begin : g_lsb
      assign word_next  = {bit_in, word[WIDTH-1:1]};
      assign first_word = {bit_in, {(WIDTH-1){1'b0}}};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      word <= '0;
    end else if (load_first) begin
      word <= first_word;
    end else if (shift_en) begin
      word <= word_next;
    end
  end

endmodule

// File: rtl/serial_deserializer.sv
// rtl/serial_deserializer.sv - framed serial-to-parallel receiver with truncated-frame detection
module serial_deserializer
  import serial_deser_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter int ERR_CNT_W = 8,
  localparam int CW       = count_width(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_en,
  input  logic                 serial_in,
  input  logic                 frame_start,
  output logic [WIDTH-1:0]     data_out,
  output logic                 data_valid,
  output logic                 busy,
  output logic [CW-1:0]        bit_count,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  deser_state_t     state, state_n;
  logic [CW-1:0]    count_n;
  logic             shift_en, load_first, complete, abort;
  logic [WIDTH-1:0] word_next;

  deser_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk        (clk),
    .rst        (rst),
    .shift_en   (shift_en),
    .load_first (load_first),
    .bit_in     (serial_in),
    .word_next  (word_next)
  );

  always_comb begin
    state_n    = state;
    count_n    = bit_count;
    shift_en   = 1'b0;
    load_first = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (bit_en && frame_start) begin
          load_first = 1'b1;
          count_n    = CW'(1);
          state_n    = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_en) begin
          if (frame_start) begin
            // Truncated frame: drop the partial word, this bit starts a new one
            abort      = 1'b1;
            load_first = 1'b1;
            count_n    = CW'(1);
          end else begin
            shift_en = 1'b1;
            if (bit_count == CW'(WIDTH - 1)) begin
              complete = 1'b1;
              count_n  = '0;
              state_n  = IDLE;
            end else begin
              count_n = bit_count + CW'(1);
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_count  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= state_n;
      bit_count  <= count_n;
      data_valid <= complete;
      frame_err  <= abort;
      if (complete) begin
        data_out <= word_next;
      end
      if (abort && (err_count != {ERR_CNT_W{1'b1}})) begin
        err_count <= err_count + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_serial_deserializer.sv
// tb/tb_serial_deserializer.sv - scoreboard bench for MSB-first, LSB-first and narrow-counter variants
module tb_serial_deserializer;

  logic clk = 1'b0;
  logic rst, bit_en, serial_in, frame_start;

  logic [3:0] m_data, l_data, e_data;
  logic       m_valid, l_valid, e_valid;
  logic       m_busy, l_busy, e_busy;
  logic [2:0] m_cnt, l_cnt, e_cnt;
  logic       m_ferr, l_ferr, e_ferr;
  logic [7:0] m_ecnt, l_ecnt;
  logic [1:0] e_ecnt;

  int total = 0;
  int bad   = 0;
  int exp_err_pulses = 0;
  int seen_err_pulses = 0;

  logic [3:0] q_m[$];
  logic [3:0] q_l[$];

  always #5 clk = ~clk;

  serial_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1), .ERR_CNT_W(8)) dut_m (
    .clk(clk), .rst(rst), .bit_en(bit_en), .serial_in(serial_in), .frame_start(frame_start),
    .data_out(m_data), .data_valid(m_valid), .busy(m_busy), .bit_count(m_cnt),
    .frame_err(m_ferr), .err_count(m_ecnt));

  serial_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0), .ERR_CNT_W(8)) dut_l (
    .clk(clk), .rst(rst), .bit_en(bit_en), .serial_in(serial_in), .frame_start(frame_start),
    .data_out(l_data), .data_valid(l_valid), .busy(l_busy), .bit_count(l_cnt),
    .frame_err(l_ferr), .err_count(l_ecnt));

  serial_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1), .ERR_CNT_W(2)) dut_e (
    .clk(clk), .rst(rst), .bit_en(bit_en), .serial_in(serial_in), .frame_start(frame_start),
    .data_out(e_data), .data_valid(e_valid), .busy(e_busy), .bit_count(e_cnt),
    .frame_err(e_ferr), .err_count(e_ecnt));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid === 1'b1) begin
      if (q_m.size() == 0) chk("m_unexpected_valid", 32'(m_data), 32'hFFFF_FFFF);
      else chk("m_data_out", 32'(m_data), 32'(q_m.pop_front()));
    end
    if (l_valid === 1'b1) begin
      if (q_l.size() == 0) chk("l_unexpected_valid", 32'(l_data), 32'hFFFF_FFFF);
      else chk("l_data_out", 32'(l_data), 32'(q_l.pop_front()));
    end
    if (m_ferr === 1'b1) seen_err_pulses++;
  end

  task automatic send(input logic b, input logic fs);
    bit_en = 1'b1;
    serial_in = b;
    frame_start = fs;
    @(posedge clk);
    #1;
    bit_en = 1'b0;
    frame_start = 1'b0;
    serial_in = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [3:0] msb_val, input logic [3:0] lsb_val);
    q_m.push_back(msb_val);
    q_l.push_back(lsb_val);
  endtask

  initial begin
    rst = 1'b1; bit_en = 1'b0; serial_in = 1'b0; frame_start = 1'b0;
    gap(2);
    rst = 1'b0;
    chk("reset_data_out", 32'(m_data), 0);
    chk("reset_valid", 32'(m_valid), 0);
    chk("reset_busy", 32'(m_busy), 0);
    chk("reset_bit_count", 32'(m_cnt), 0);
    chk("reset_frame_err", 32'(m_ferr), 0);
    chk("reset_err_count", 32'(m_ecnt), 0);

    // bits without frame_start in IDLE are ignored
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    chk("idle_ignore_busy", 32'(m_busy), 0);
    chk("idle_ignore_count", 32'(m_cnt), 0);

    // 1,0,1,1 with a 3-cycle bit_en gap after bit 2
    expect_word(4'hB, 4'hD);
    send(1'b1, 1'b1);
    chk("start_busy", 32'(m_busy), 1);
    chk("start_count", 32'(m_cnt), 1);
    send(1'b0, 1'b0);
    gap(3);
    chk("gap_count_m", 32'(m_cnt), 2);
    chk("gap_count_l", 32'(l_cnt), 2);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    chk("done_busy", 32'(m_busy), 0);
    chk("done_valid", 32'(m_valid), 1);
    chk("done_count", 32'(m_cnt), 0);
    chk("done_frame_err", 32'(m_ferr), 0);
    gap(2);

    // back-to-back 4'hB then 4'h6
    expect_word(4'hB, 4'hD);
    expect_word(4'h6, 4'h6);
    send(1'b1, 1'b1); send(1'b0, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b0);
    send(1'b0, 1'b1); send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b0, 1'b0);
    chk("b2b_valid", 32'(m_valid), 1);
    gap(2);

    // 2 bits, then frame_start restarts with 0,1,1,0
    expect_word(4'h6, 4'h6);
    send(1'b1, 1'b1); send(1'b0, 1'b0);
    send(1'b0, 1'b1);
    exp_err_pulses++;
    chk("abort_frame_err", 32'(m_ferr), 1);
    chk("abort_err_count", 32'(m_ecnt), 1);
    chk("abort_count", 32'(m_cnt), 1);
    chk("abort_busy", 32'(m_busy), 1);
    chk("abort_valid", 32'(m_valid), 0);
    send(1'b1, 1'b0);
    chk("abort_pulse_once", 32'(m_ferr), 0);
    send(1'b1, 1'b0); send(1'b0, 1'b0);
    gap(2);
    chk("after_abort_data", 32'(m_data), 32'h6);

    // reset mid-frame, then 4'hA
    send(1'b1, 1'b1); send(1'b0, 1'b0); send(1'b1, 1'b0);
    rst = 1'b1;
    gap(1);
    rst = 1'b0;
    chk("midrst_data", 32'(m_data), 0);
    chk("midrst_busy", 32'(m_busy), 0);
    chk("midrst_count", 32'(m_cnt), 0);
    chk("midrst_err_count", 32'(m_ecnt), 0);
    chk("midrst_valid", 32'(m_valid), 0);
    expect_word(4'hA, 4'h5);
    send(1'b1, 1'b1); send(1'b0, 1'b0); send(1'b1, 1'b0); send(1'b0, 1'b0);
    gap(2);

    // five aborted frames: 2-bit counter saturates at 3
    send(1'b1, 1'b1); send(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 1'b1); send(1'b0, 1'b0);
      exp_err_pulses++;
    end
    chk("sat_err_count_e", 32'(e_ecnt), 3);
    chk("sat_err_count_m", 32'(m_ecnt), 5);
    expect_word(4'hB, 4'hD);
    send(1'b1, 1'b0); send(1'b1, 1'b0);
    gap(3);

    chk("scoreboard_m_drained", 32'(q_m.size()), 0);
    chk("scoreboard_l_drained", 32'(q_l.size()), 0);
    chk("frame_err_pulses", 32'(seen_err_pulses), 32'(exp_err_pulses));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
